// File: rtl/regfile_mp_if.sv
// Register file bus: read ports, write ports and the issue-side scoreboard hook.
// The master drives requests; the register file (slave) returns read data and busy status.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1
);
   logic [NREAD-1:0]         rd_en;
   logic [NREAD*ADDR_W-1:0]  rd_addr;
   logic [NREAD*DATA_W-1:0]  rd_data;
   logic [NREAD-1:0]         rd_busy;
   logic [NWRITE-1:0]        wr_en;
   logic [NWRITE*ADDR_W-1:0] wr_addr;
   logic [NWRITE*DATA_W-1:0] wr_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first read bypass, hardwired-zero register 0
// and a per-register busy scoreboard for RAW hazard detection at issue.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1
) (
   input logic          clk,
   input logic          reset,
   regfile_mp_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]       regs     [DEPTH];
   logic [DATA_W-1:0]       nxt_regs [DEPTH];
   logic [DEPTH-1:0]        busy;
   logic [DEPTH-1:0]        nxt_busy;
   logic [DEPTH-1:0]        wr_hit;
   logic [NREAD*DATA_W-1:0] rd_q;
   logic [NREAD-1:0]        rd_busy_c;

   // Post-write register image; later ports overwrite earlier ones, so the
   // highest-index port wins and reads of nxt_regs see the write-first value.
   always_comb begin
      logic [ADDR_W-1:0] wa;
      wa = '0;
      wr_hit = '0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
         nxt_regs[r] = regs[r];
      end
      for (int unsigned w = 0; w < NWRITE; w++) begin
         wa = bus.wr_addr[w*ADDR_W +: ADDR_W];
         if (bus.wr_en[w] && wa != '0) begin
            nxt_regs[wa] = bus.wr_data[w*DATA_W +: DATA_W];
            wr_hit[wa]   = 1'b1;
         end
      end
      nxt_regs[0] = '0;
   end

   // Writeback clears first, then a same-cycle issue re-sets (newer instruction wins).
   always_comb begin
      nxt_busy = busy & ~wr_hit;
      if (bus.iss_en && bus.iss_addr != '0) begin
         nxt_busy[bus.iss_addr] = 1'b1;
      end
      nxt_busy[0] = 1'b0;
   end

   always_comb begin
      logic [ADDR_W-1:0] ra;
      ra = '0;
      rd_busy_c = '0;
      for (int unsigned i = 0; i < NREAD; i++) begin
         ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
         rd_busy_c[i] = busy[ra] && !wr_hit[ra] && (ra != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
         busy <= '0;
         rd_q <= '0;
      end else begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            regs[r] <= nxt_regs[r];
         end
         busy <= nxt_busy;
         for (int unsigned i = 0; i < NREAD; i++) begin
            if (bus.rd_en[i]) begin
               rd_q[i*DATA_W +: DATA_W] <= nxt_regs[bus.rd_addr[i*ADDR_W +: ADDR_W]];
            end
         end
      end
   end

   assign bus.rd_data = rd_q;
   assign bus.rd_busy = rd_busy_c;
endmodule
